dec_pipe: RTL and testbench

DEC_PIPE -- requirements
Module: dec_pipe

---
 rtl/dec_pkg.sv | 14 +
 rtl/dec_mode.sv | 31 +++
 rtl/dec_pipe.sv | 111 +++++++++++
 tb/tb_dec_pipe.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types and constants for the decode pipeline: decode modes and
// the default width of the out-of-range event counter.
package dec_pkg;

  typedef enum logic [1:0] {
    ONEHOT   = 2'd0,
    THERM_LE = 2'd1,
    THERM_GT = 2'd2,
    ONECOLD  = 2'd3
  } mode_e;

  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/dec_mode.sv
// Combinational index decoder: one-hot, thermometer (<= / >) and one-cold
// patterns, forcing all zeros and flagging indices at or beyond W.
module dec_mode
  import dec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [$clog2(W)-1:0] x,
  input  mode_e                mode,
  output logic [W-1:0]         y,
  output logic                 oor
);

  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    y   = '0;
    oor = (int'(x) >= W);
    if (!oor) begin
      for (int i = 0; i < W; i++) begin
        case (mode)
          ONEHOT:   y[i] = (int'(x) == i);
          THERM_LE: y[i] = (i <= int'(x));
          THERM_GT: y[i] = (i > int'(x));
          default:  y[i] = (int'(x) != i);
        endcase
      end
    end
  end

endmodule

// File: rtl/dec_pipe.sv
// Decode pipeline: registered decode result behind a two-entry (output + skid)
// valid/ready buffer, plus a saturating count of out-of-range acceptances.
module dec_pipe
  import dec_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 i_vld,
  input  logic [$clog2(W)-1:0] i_x,
  input  logic [1:0]           i_mode,
  output logic                 o_rdy,
  output logic                 o_vld,
  output logic [W-1:0]         o_y,
  output logic                 o_oor,
  input  logic                 i_rdy,
  input  logic                 i_cnt_clr,
  output logic [CNT_W-1:0]     o_oor_cnt
);

  logic [W-1:0]     dec_y;
  logic             dec_oor;
  logic             accept;

  logic             out_vld, out_vld_d;
  logic [W-1:0]     out_y, out_y_d;
  logic             out_oor, out_oor_d;
  logic             skid_vld, skid_vld_d;
  logic [W-1:0]     skid_y, skid_y_d;
  logic             skid_oor, skid_oor_d;
  logic             rdy_q;
  logic [CNT_W-1:0] cnt;

  dec_mode #(.W(W)) u_dec (
    .x    (i_x),
    .mode (mode_e'(i_mode)),
    .y    (dec_y),
    .oor  (dec_oor)
  );

  assign accept = i_vld & rdy_q;

  always_comb begin
    out_vld_d  = out_vld;
    out_y_d    = out_y;
    out_oor_d  = out_oor;
    skid_vld_d = skid_vld;
    skid_y_d   = skid_y;
    skid_oor_d = skid_oor;
    // The output slot frees up when it is empty or being consumed this cycle.
    if (!out_vld || i_rdy) begin
      if (skid_vld) begin
        out_vld_d  = 1'b1;
        out_y_d    = skid_y;
        out_oor_d  = skid_oor;
        skid_vld_d = accept;
        if (accept) begin
          skid_y_d   = dec_y;
          skid_oor_d = dec_oor;
        end
      end else begin
        out_vld_d = accept;
        if (accept) begin
          out_y_d   = dec_y;
          out_oor_d = dec_oor;
        end
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_y_d   = dec_y;
      skid_oor_d = dec_oor;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_vld  <= 1'b0;
      out_y    <= '0;
      out_oor  <= 1'b0;
      skid_vld <= 1'b0;
      skid_y   <= '0;
      skid_oor <= 1'b0;
      rdy_q    <= 1'b1;
      cnt      <= '0;
    end else begin
      out_vld  <= out_vld_d;
      out_y    <= out_y_d;
      out_oor  <= out_oor_d;
      skid_vld <= skid_vld_d;
      skid_y   <= skid_y_d;
      skid_oor <= skid_oor_d;
      rdy_q    <= ~skid_vld_d;
      if (i_cnt_clr) begin
        cnt <= (accept && dec_oor) ? CNT_W'(1) : '0;
      end else if (accept && dec_oor && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign o_rdy     = rdy_q;
  assign o_vld     = out_vld;
  assign o_y       = out_y;
  assign o_oor     = out_oor;
  assign o_oor_cnt = cnt;

endmodule

// File: tb/tb_dec_pipe.sv
// Self-checking bench for dec_pipe: a W=8 and a W=5 instance, each checked
// against a FIFO-of-results reference model with arithmetic decode.
module tb_dec_pipe;

  logic       clk = 1'b0;
  logic       arst;
  logic       vld0, rdy0, clr0, vld1, rdy1, clr1;
  logic [2:0] x0, x1;
  logic [1:0] m0, m1;
  logic       o_rdy0, o_vld0, o_oor0, o_rdy1, o_vld1, o_oor1;
  logic [7:0] y0, cnt0, cnt1;
  logic [4:0] y1;

  int tests = 0;
  int fails = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         mcnt0, mcnt1;

  always #5 clk = ~clk;

  dec_pipe #(.W(8), .CNT_W(8)) d8 (
    .clk(clk), .arst(arst), .i_vld(vld0), .i_x(x0), .i_mode(m0),
    .o_rdy(o_rdy0), .o_vld(o_vld0), .o_y(y0), .o_oor(o_oor0),
    .i_rdy(rdy0), .i_cnt_clr(clr0), .o_oor_cnt(cnt0)
  );

  dec_pipe #(.W(5), .CNT_W(8)) d5 (
    .clk(clk), .arst(arst), .i_vld(vld1), .i_x(x1), .i_mode(m1),
    .o_rdy(o_rdy1), .o_vld(o_vld1), .o_y(y1), .o_oor(o_oor1),
    .i_rdy(rdy1), .i_cnt_clr(clr1), .o_oor_cnt(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {oor, y} for a W-wide decode, using plain mask arithmetic.
  function automatic logic [8:0] ref_dec(input int w, input int x, input int m);
    int mask, oh, le;
    if (x >= w) return 9'h100;
    mask = (1 << w) - 1;
    oh   = 1 << x;
    le   = (1 << (x + 1)) - 1;
    case (m)
      0:       return {1'b0, 8'(oh)};
      1:       return {1'b0, 8'(le)};
      2:       return {1'b0, 8'(mask & ~le)};
      default: return {1'b0, 8'(mask & ~oh)};
    endcase
  endfunction

  function automatic int cnt_next(input int c, input bit clr, input bit ev);
    if (clr) return ev ? 1 : 0;
    if (ev && c < 255) return c + 1;
    return c;
  endfunction

  task automatic check_outputs();
    check("d8_vld", 32'(o_vld0), 32'(q0.size() > 0));
    check("d8_rdy", 32'(o_rdy0), 32'(q0.size() < 2));
    check("d8_cnt", 32'(cnt0), 32'(mcnt0));
    if (q0.size() > 0) begin
      check("d8_y",   32'(y0),     32'(q0[0][7:0]));
      check("d8_oor", 32'(o_oor0), 32'(q0[0][8]));
    end
    check("d5_vld", 32'(o_vld1), 32'(q1.size() > 0));
    check("d5_rdy", 32'(o_rdy1), 32'(q1.size() < 2));
    check("d5_cnt", 32'(cnt1), 32'(mcnt1));
    if (q1.size() > 0) begin
      check("d5_y",   32'(y1),     32'(q1[0][4:0]));
      check("d5_oor", 32'(o_oor1), 32'(q1[0][8]));
    end
  endtask

  // One clock: handshakes decided from the model's occupancy, then compared.
  task automatic step();
    bit acc0, acc1, con0, con1;
    logic [8:0] r0, r1;
    @(negedge clk);
    acc0 = vld0 && (q0.size() < 2);
    con0 = rdy0 && (q0.size() > 0);
    acc1 = vld1 && (q1.size() < 2);
    con1 = rdy1 && (q1.size() > 0);
    r0 = ref_dec(8, int'(x0), int'(m0));
    r1 = ref_dec(5, int'(x1), int'(m1));
    @(posedge clk);
    if (con0) void'(q0.pop_front());
    if (acc0) q0.push_back(r0);
    if (con1) void'(q1.pop_front());
    if (acc1) q1.push_back(r1);
    mcnt0 = cnt_next(mcnt0, clr0, acc0 && r0[8]);
    mcnt1 = cnt_next(mcnt1, clr1, acc1 && r1[8]);
    #1;
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    {vld0, rdy0, clr0, vld1, rdy1, clr1} = '0;
    x0 = '0; x1 = '0; m0 = '0; m1 = '0;
    mcnt0 = 0; mcnt1 = 0;

    // Reset state, asynchronous: checked before any clock edge.
    #3;
    check("rst_vld", 32'(o_vld0), 32'd0);
    check("rst_rdy", 32'(o_rdy0), 32'd1);
    check("rst_y",   32'(y0),     32'd0);
    check("rst_oor", 32'(o_oor0), 32'd0);
    check("rst_cnt", 32'(cnt0),   32'd0);
    check("rst_rdy5", 32'(o_rdy1), 32'd1);
    #4 arst = 1'b0;

    // Basic decode of x=3 in all four modes, first edge after reset.
    rdy0 = 1'b1; rdy1 = 1'b1; vld0 = 1'b1; x0 = 3'd3;
    m0 = 2'd0; step(); check("onehot3",  32'(y0), 32'h08); check("onehot3_oor", 32'(o_oor0), 32'd0);
    m0 = 2'd1; step(); check("therm_le3", 32'(y0), 32'h0F);
    m0 = 2'd2; step(); check("therm_gt3", 32'(y0), 32'hF0);
    m0 = 2'd3; step(); check("onecold3", 32'(y0), 32'hF7);
    vld0 = 1'b0; step();

    // Skid behaviour: three back-to-back inputs against a stalled sink.
    rdy0 = 1'b0; vld0 = 1'b1; m0 = 2'd0;
    x0 = 3'd1; step();
    x0 = 3'd2; step(); check("skid_hold_y", 32'(y0), 32'h02); check("skid_full_rdy", 32'(o_rdy0), 32'd0);
    x0 = 3'd3; step(); check("stall_hold_y", 32'(y0), 32'h02);
    rdy0 = 1'b1; step(); check("drain_y1", 32'(y0), 32'h04);
    step(); check("drain_y2", 32'(y0), 32'h08);
    vld0 = 1'b0; step(); check("drain_empty", 32'(o_vld0), 32'd0);

    // Out-of-range on W=5: zeros, flag, counter saturation, clear+event.
    vld1 = 1'b1; x1 = 3'd6; m1 = 2'd1;
    step();
    check("oor_y", 32'(y1), 32'd0); check("oor_flag", 32'(o_oor1), 32'd1); check("oor_cnt1", 32'(cnt1), 32'd1);
    for (int i = 1; i < 300; i++) begin
      m1 = 2'($urandom_range(0, 3));
      step();
    end
    check("oor_sat", 32'(cnt1), 32'd255);
    clr1 = 1'b1; step(); check("clr_plus_evt", 32'(cnt1), 32'd1);
    clr1 = 1'b0; vld1 = 1'b0; step();

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      vld0 = ($urandom_range(0, 3) != 0);
      vld1 = ($urandom_range(0, 3) != 0);
      rdy0 = ($urandom_range(0, 9) < 6);
      rdy1 = ($urandom_range(0, 9) < 6);
      x0 = 3'($urandom_range(0, 7));
      x1 = 3'($urandom_range(0, 7));
      m0 = 2'($urandom_range(0, 3));
      m1 = 2'($urandom_range(0, 3));
      clr0 = ($urandom_range(0, 31) == 0);
      clr1 = ($urandom_range(0, 31) == 0);
      step();
    end
    clr0 = 1'b0; clr1 = 1'b0;

    // Reset mid-transfer with both entries full.
    rdy0 = 1'b0; rdy1 = 1'b0; vld0 = 1'b1; vld1 = 1'b1; x0 = 3'd5; x1 = 3'd7;
    step(); step(); step();
    check("full_before_rst", 32'(o_rdy0), 32'd0);
    arst = 1'b1;
    #1;
    check("arst_vld", 32'(o_vld0), 32'd0);
    check("arst_rdy", 32'(o_rdy0), 32'd1);
    check("arst_cnt", 32'(cnt1),   32'd0);
    check("arst_y",   32'(y0),     32'd0);
    q0.delete(); q1.delete(); mcnt0 = 0; mcnt1 = 0;
    vld0 = 1'b0; vld1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
    #1 arst = 1'b0;
    step(); step();
    check("no_stale", 32'(o_vld0), 32'd0);
    vld0 = 1'b1; x0 = 3'd0; m0 = 2'd0; step();
    check("post_rst_y", 32'(y0), 32'h01);
    vld0 = 1'b0; step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
